dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the methane core's load/store port: the memory-side end of the core's address / write-data / byte-enable / read-data interface. Accepts one request at a time over a valid/ready handshake, performs byte-lane writes or offset-aligned reads against an internal word array after a programmable latency, and returns a single-cycle response. Data crosses the port in the core's byte-swapped wire order; the array stores little-endian logical words.

## Interface
- ADDR_WIDTH, 12, word-index width; DEPTH = 2**ADDR_WIDTH 32-bit words, byte base address 0.
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_addr  in  32  byte address.
- req_we  in  4  logical byte-lane write mask; 0 = read.
- req_wdata  in  32  write data, wire order: logical byte i at bits [31-8i : 24-8i].
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  read data, wire order, registered, held until next response.
- resp_err  out  1  qualified by resp_valid; request rejected.

## Operation
- Acceptance: req_valid && req_ready at a rising edge. Request fields sampled then; later changes ignored.
- Logical data: wdata_l = byte-swap(req_wdata). Offset o = req_addr[1:0], word index w = req_addr[ADDR_WIDTH+1:2].
- Error if req_addr[31:ADDR_WIDTH+2] != 0 (out of range), or write with (req_we << o) having bits above lane 3 (misaligned). Error: no memory write, resp_rdata = 0, resp_err = 1.
- Write (req_we != 0, no error): lane mask m = (req_we << o)[3:0], data d = wdata_l << 8o; byte j of mem[w] <= d byte j where m[j]. resp_rdata = 0.
- Read (req_we == 0, no error): logical result = mem[w] >> 8o, zero-filled upper bytes (byte at req_addr lands in logical byte 0); resp_rdata = byte-swap(result). Any offset legal for reads.
- States: IDLE (req_ready=1) -> on acceptance: WAIT if LATENCY>1, else RESP. WAIT: down-counter loaded with LATENCY-1, decremented each cycle; at 1 -> RESP. RESP: resp_valid=1 one cycle, -> IDLE.
- Memory write and read-data capture occur at the edge entering RESP; read reflects all earlier committed writes.
- Memory array not cleared by reset.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, state IDLE, counter 0.
- Accept in cycle k -> req_ready=0 in k+1..k+LATENCY, resp_valid=1 in cycle k+LATENCY only, req_ready=1 again in k+LATENCY+1.
- Throughput: one request per LATENCY+1 cycles; no back-to-back acceptance in the RESP cycle.
- req_valid while req_ready=0: ignored, not queued.
- resp_err is 0 whenever resp_valid is 0.
- Reset mid-operation (WAIT or before RESP edge): request dropped, no write, no response; IDLE next cycle. Reset in the RESP cycle: the write has already committed; outputs return to reset values.

## Test plan
- Reset, LATENCY=2: hold rstn low 2 cycles then release -> req_ready=1, resp_valid=0, resp_rdata=0 every cycle until a request.
- Write 0x10, req_we=4'b1111, req_wdata=0x44332211 (logical 0x11223344), accept cycle k; read 0x10 -> resp_valid only in k+2, read resp_rdata=0x44332211, resp_err=0; req_ready low exactly 2 cycles per request.
- Byte write 0x11, req_we=4'b0001, logical 0x000000AB; read 0x10 -> logical 0x1122AB44 (wire 0x44AB2211).
- Offset read 0x13 after previous -> logical 0x00000011 (wire 0x11000000); read 0x12 -> logical 0x00001122.
- Errors: write 0x13 req_we=4'b0011 -> resp_err=1, rdata 0, word 0x10 unchanged on read-back; read at byte address 4*DEPTH -> resp_err=1.
- Reset abort, LATENCY=4: write 0x20 0xFFFFFFFF, rstn low in k+1 -> no resp_valid; later read 0x20 returns prior contents; LATENCY=1 run of 100 random mixed requests matches scoreboard with resp_valid in k+1.

Source files
------------

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dmem_responder_if
// Brief    : Load/store port bundle between the core and the data-memory responder.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_we;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dmem_responder
// Brief    : Single-outstanding data-memory responder with byte-lane writes,
//            offset reads and a fixed programmable response latency.
// Revision : 1.0
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  wire logic       clk,
  input  wire logic       rstn,
  dmem_responder_if.slave bus
);

  localparam int         c_depth  = 2 ** ADDR_WIDTH;
  localparam logic [3:0] c_lat_m1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;

  logic [31:0] r_addr;
  logic [3:0]  r_we;
  logic [31:0] r_wdata_l;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [c_depth];

  logic                  w_accept;
  logic                  w_enter_resp;
  logic [31:0]           w_op_addr;
  logic [3:0]            w_op_we;
  logic [31:0]           w_op_wdata_l;
  logic [1:0]            w_off;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_oor;
  logic [7:0]            w_mask_wide;
  logic [3:0]            w_mask;
  logic                  w_misalign;
  logic                  w_err;
  logic [31:0]           w_wdata_sh;
  logic [31:0]           w_rd_l;

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_err   = r_err && (r_state == S_RESP);
  assign bus.resp_rdata = r_rdata;

  assign w_accept     = bus.req_valid && (r_state == S_IDLE);
  assign w_enter_resp = (w_state_nxt == S_RESP);

  // With LATENCY==1 RESP is entered on the acceptance edge, so the live
  // request fields must feed the memory operation directly.
  assign w_op_addr    = (r_state == S_IDLE) ? bus.req_addr         : r_addr;
  assign w_op_we      = (r_state == S_IDLE) ? bus.req_we           : r_we;
  assign w_op_wdata_l = (r_state == S_IDLE) ? bswap(bus.req_wdata) : r_wdata_l;

  assign w_off       = w_op_addr[1:0];
  assign w_idx       = w_op_addr[ADDR_WIDTH+1:2];
  assign w_oor       = (w_op_addr >> (ADDR_WIDTH + 2)) != 32'd0;
  assign w_mask_wide = {4'b0000, w_op_we} << w_off;
  assign w_misalign  = (w_mask_wide[7:4] != 4'b0000);
  assign w_err       = w_oor || w_misalign;
  assign w_mask      = w_mask_wide[3:0];
  assign w_wdata_sh  = w_op_wdata_l << {w_off, 3'b000};
  assign w_rd_l      = r_mem[w_idx] >> {w_off, 3'b000};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY > 1) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_lat_m1;
          end else begin
            w_state_nxt = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_RESP;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_addr    <= 32'd0;
      r_we      <= 4'd0;
      r_wdata_l <= 32'd0;
    end else if (w_accept) begin
      r_addr    <= bus.req_addr;
      r_we      <= bus.req_we;
      r_wdata_l <= bswap(bus.req_wdata);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_err <= w_err;
      if (w_err || (w_op_we != 4'd0)) begin
        r_rdata <= 32'd0;
      end else begin
        r_rdata <= bswap(w_rd_l);
      end
    end
  end

  // Array contents survive reset; only the commit itself is suppressed by it.
  always_ff @(posedge clk) begin
    if (rstn && w_enter_resp && !w_err) begin
      for (int j = 0; j < 4; j++) begin
        if (w_mask[j]) begin
          r_mem[w_idx][8*j +: 8] <= w_wdata_sh[8*j +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire
